eth_udprx: RTL and testbench

ETH_UDPRX -- requirements
Module: eth_udprx

---
 rtl/eth_pkg.sv | 16 +
 rtl/eth_rx_crc32.sv | 24 ++
 rtl/eth_udprx.sv | 137 +++++++++++++
 tb/tb_eth_udprx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: receive-path state encodings, protocol constants and CRC-32 helpers
package eth_pkg;
  typedef enum logic [3:0] {
    IDLE, PREAMBLE, MAC_DST, MAC_SRC, MAC_TYPE, IP_HDR, UDP_HDR, UDP_PAYLOAD, TRAILER, DROP
  } state_t;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31 - i];
    return r;
  endfunction
endpackage

// File: rtl/eth_rx_crc32.sv
// eth_rx_crc32: byte-wide reflected CRC-32 accumulator
// ports: eth_rx_clk/reset_i; init loads all-ones; calc & d_valid fold data into crc
module eth_rx_crc32
  import eth_pkg::*;
(
  input  logic        eth_rx_clk,
  input  logic        reset_i,
  input  logic        init,
  input  logic        calc,
  input  logic        d_valid,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  localparam logic [31:0] POLY_R = rev32(CRC_POLY);
  logic [31:0] nxt;
  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8; i++) nxt = (nxt >> 1) ^ (POLY_R & {32{nxt[0] ^ data[i]}});
  end
  always_ff @(posedge eth_rx_clk or posedge reset_i)
    if (reset_i) crc <= '1;
    else if (init) crc <= '1;
    else if (calc && d_valid) crc <= nxt;
endmodule

// File: rtl/eth_udprx.sv
// eth_udprx: MII nibble receiver filtering Ethernet/IPv4/UDP frames and streaming the payload
// ports: eth_rx_* MII input; usr_ethdst_i/usr_ipdst_i/usr_udpport_i filter values;
//        usr_data_o/usr_dv_o/usr_sof_o/usr_data_len_o payload stream; usr_done_o/usr_crc_ok_o/usr_drop_o frame status
module eth_udprx
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic        eth_rx_clk,
  input  logic        reset_i,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  input  logic [47:0] usr_ethdst_i,
  input  logic [31:0] usr_ipdst_i,
  input  logic [15:0] usr_udpport_i,
  output logic [7:0]  usr_data_o,
  output logic        usr_dv_o,
  output logic        usr_sof_o,
  output logic [15:0] usr_data_len_o,
  output logic        usr_done_o,
  output logic        usr_crc_ok_o,
  output logic        usr_drop_o
);
  localparam logic [16:0] LEN_MAX = 17'(MAX_PAYLOAD + 8);
  // the register holds the bit-reflected residue
  localparam logic [31:0] RESIDUE_R = rev32(CRC_RESIDUE);
  state_t state, nxt;
  logic dv_q, hi, mu, mb, hdr, byte_en, bad, last, u_ok, b_ok;
  logic dv_n, done_n, drop_n, crc_ok_n;
  logic [3:0] lo;
  logic [7:0] byte_v, len_hi, mac_b, ip_b;
  logic [15:0] cnt, length, len_n;
  logic [31:0] crc;
  assign hdr = state inside {MAC_DST, MAC_SRC, MAC_TYPE, IP_HDR, UDP_HDR, UDP_PAYLOAD, TRAILER};
  assign byte_en = eth_rx_dv && !eth_rx_er && hi && hdr;
  assign byte_v = {eth_rx_data, lo};
  assign length = {len_hi, byte_v};
  assign mac_b = 8'(usr_ethdst_i >> (6'd40 - {cnt[2:0], 3'b000}));
  assign ip_b = 8'(usr_ipdst_i >> (5'd24 - {cnt[1:0], 3'b000}));
  assign u_ok = (cnt == 0 || mu) && byte_v == mac_b;
  assign b_ok = (cnt == 0 || mb) && byte_v == 8'hFF;
  eth_rx_crc32 u_crc (
    .eth_rx_clk(eth_rx_clk),
    .reset_i(reset_i),
    .init(state == PREAMBLE),
    .calc(hdr),
    .d_valid(byte_en),
    .data(byte_v),
    .crc(crc)
  );
  always_comb begin
    bad = 1'b0;
    last = 1'b0;
    case (state)
      MAC_DST: begin
        bad = !(u_ok || b_ok);
        last = cnt == 5;
      end
      MAC_SRC: last = cnt == 5;
      MAC_TYPE: begin
        bad = byte_v != (cnt[0] ? ETH_TYPE_IP[7:0] : ETH_TYPE_IP[15:8]);
        last = cnt == 1;
      end
      IP_HDR: begin
        bad = (cnt == 0 && byte_v != IP_VER_IHL) || (cnt == 9 && byte_v != IP_PROTO_UDP) ||
              (cnt >= 16 && byte_v != ip_b);
        last = cnt == 19;
      end
      UDP_HDR: begin
        bad = (cnt == 2 && byte_v != usr_udpport_i[15:8]) || (cnt == 3 && byte_v != usr_udpport_i[7:0]) ||
              (cnt == 5 && (length < 8 || {1'b0, length} > LEN_MAX));
        last = cnt == 7;
      end
      UDP_PAYLOAD: last = cnt == usr_data_len_o - 16'd1;
      default: ;
    endcase
  end
  always_ff @(posedge eth_rx_clk or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = eth_rx_dv && !dv_q ? (eth_rx_data == 4'h5 && !eth_rx_er ? PREAMBLE : DROP) : IDLE;
    else if (!eth_rx_dv) nxt = IDLE;
    else if (eth_rx_er) nxt = DROP;
    else if (state == PREAMBLE)
      nxt = eth_rx_data == 4'h5 ? PREAMBLE : eth_rx_data == 4'hD ? MAC_DST : DROP;
    else if (byte_en)
      nxt = bad ? DROP : !last ? state :
            state == UDP_HDR && usr_data_len_o == 0 ? TRAILER : state_t'(state + 4'd1);
  end
  always_comb begin
    dv_n = byte_en && state == UDP_PAYLOAD;
    // hi clear at the dv fall means an even number of nibbles since MAC_DST
    done_n = state == TRAILER && !eth_rx_dv && !hi;
    drop_n = state != IDLE && !eth_rx_dv && !done_n;
    crc_ok_n = done_n && crc == RESIDUE_R;
    len_n = byte_en && state == UDP_HDR && cnt == 5 && !bad ? length - 16'd8 : usr_data_len_o;
  end
  always_ff @(posedge eth_rx_clk or posedge reset_i)
    if (reset_i) begin
      // dv_q starts high so a frame already in flight at reset release is not seen as a rising edge
      dv_q <= 1'b1;
      hi <= 1'b0;
      lo <= '0;
      cnt <= '0;
      mu <= 1'b0;
      mb <= 1'b0;
      len_hi <= '0;
      usr_data_o <= '0;
      usr_dv_o <= 1'b0;
      usr_sof_o <= 1'b0;
      usr_data_len_o <= '0;
      usr_done_o <= 1'b0;
      usr_crc_ok_o <= 1'b0;
      usr_drop_o <= 1'b0;
    end else begin
      dv_q <= eth_rx_dv;
      hi <= hdr && (hi ^ eth_rx_dv);
      lo <= eth_rx_data;
      cnt <= nxt != state ? 16'd0 : byte_en ? cnt + 16'd1 : cnt;
      if (byte_en && state == MAC_DST) begin
        mu <= u_ok;
        mb <= b_ok;
      end
      if (byte_en && state == UDP_HDR && cnt == 4) len_hi <= byte_v;
      if (dv_n) usr_data_o <= byte_v;
      usr_dv_o <= dv_n;
      usr_sof_o <= dv_n && cnt == 0;
      usr_data_len_o <= len_n;
      usr_done_o <= done_n;
      usr_crc_ok_o <= crc_ok_n;
      usr_drop_o <= drop_n;
    end
endmodule

// File: tb/tb_eth_udprx.sv
// tb_eth_udprx: randomized frame stimulus with a parsing reference model and an event scoreboard
module tb_eth_udprx;
  localparam int MAXP = 64;
  localparam logic [47:0] MY_MAC = 48'h02_12_34_56_78_9A;
  localparam logic [31:0] MY_IP = 32'hC0A8010A;
  localparam logic [15:0] MY_PORT = 16'h1F90;
  typedef struct {
    int kind;
    logic [7:0] data;
    logic sof;
    logic [15:0] len;
    logic crc;
  } ev_t;
  logic eth_rx_clk = 1'b0, reset_i = 1'b1, eth_rx_dv = 1'b0, eth_rx_er = 1'b0;
  logic [3:0] eth_rx_data = '0;
  logic [47:0] usr_ethdst_i = MY_MAC;
  logic [31:0] usr_ipdst_i = MY_IP;
  logic [15:0] usr_udpport_i = MY_PORT;
  logic [7:0] usr_data_o;
  logic usr_dv_o, usr_sof_o, usr_done_o, usr_crc_ok_o, usr_drop_o;
  logic [15:0] usr_data_len_o;
  ev_t exp_q[$];
  logic [7:0] fr[$];
  logic [7:0] pay[$];
  int n_cmp = 0, n_bad = 0;
  always #5 eth_rx_clk = ~eth_rx_clk;
  eth_udprx #(.MAX_PAYLOAD(MAXP)) dut (
    .eth_rx_clk(eth_rx_clk),
    .reset_i(reset_i),
    .eth_rx_data(eth_rx_data),
    .eth_rx_dv(eth_rx_dv),
    .eth_rx_er(eth_rx_er),
    .usr_ethdst_i(usr_ethdst_i),
    .usr_ipdst_i(usr_ipdst_i),
    .usr_udpport_i(usr_udpport_i),
    .usr_data_o(usr_data_o),
    .usr_dv_o(usr_dv_o),
    .usr_sof_o(usr_sof_o),
    .usr_data_len_o(usr_data_len_o),
    .usr_done_o(usr_done_o),
    .usr_crc_ok_o(usr_crc_ok_o),
    .usr_drop_o(usr_drop_o)
  );
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic chk_zero(input string tag);
    cmp({tag, " data"}, 32'(usr_data_o), 0);
    cmp({tag, " dv"}, 32'(usr_dv_o), 0);
    cmp({tag, " sof"}, 32'(usr_sof_o), 0);
    cmp({tag, " len"}, 32'(usr_data_len_o), 0);
    cmp({tag, " done"}, 32'(usr_done_o), 0);
    cmp({tag, " crc_ok"}, 32'(usr_crc_ok_o), 0);
    cmp({tag, " drop"}, 32'(usr_drop_o), 0);
  endtask
  task automatic pop_chk(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected event: got kind %0d want none", kind);
    end else begin
      e = exp_q.pop_front();
      cmp("event kind", kind, e.kind);
      if (kind == 0) begin
        cmp("payload byte", 32'(usr_data_o), 32'(e.data));
        cmp("sof", 32'(usr_sof_o), 32'(e.sof));
        cmp("data len", 32'(usr_data_len_o), 32'(e.len));
      end else if (kind == 1) begin
        cmp("crc ok", 32'(usr_crc_ok_o), 32'(e.crc));
        cmp("len at done", 32'(usr_data_len_o), 32'(e.len));
      end
    end
  endtask
  always @(negedge eth_rx_clk)
    if (!reset_i) begin
      if (usr_dv_o) pop_chk(0);
      if (usr_done_o) pop_chk(1);
      if (usr_drop_o) pop_chk(2);
    end
  // standard Ethernet FCS over fr[0..n-1]
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic build(input logic [47:0] dst, input logic [15:0] port);
    logic [15:0] ul = 16'(pay.size() + 8);
    logic [15:0] tl = 16'(pay.size() + 28);
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(dst[47 - 8 * i -: 8]);
    fr = {fr, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
    fr = {fr, 8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00};
    fr = {fr, 8'hC0, 8'hA8, 8'h01, 8'h01, MY_IP[31:24], MY_IP[23:16], MY_IP[15:8], MY_IP[7:0]};
    fr = {fr, 8'h30, 8'h39, port[15:8], port[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
    fr = {fr, pay};
    while (fr.size() < 60) fr.push_back(8'h00);
  endtask
  task automatic add_fcs();
    logic [31:0] c = fcs_of(fr.size());
    fr = {fr, c[7:0], c[15:8], c[23:16], c[31:24]};
  endtask
  // parses the wire bytes and predicts the user-side events
  task automatic model(input int er_at, input bit odd);
    logic [47:0] dst;
    logic [31:0] ip;
    logic [15:0] typ, port, len;
    bit ok;
    int n = fr.size();
    for (int i = 0; i < 6; i++) dst = {dst[39:0], fr[i]};
    for (int i = 0; i < 4; i++) ip = {ip[23:0], fr[30 + i]};
    typ = {fr[12], fr[13]};
    port = {fr[36], fr[37]};
    len = {fr[38], fr[39]};
    ok = (dst == MY_MAC || dst == '1) && typ == 16'h0800 && fr[14] == 8'h45 && fr[23] == 8'h11 &&
         ip == MY_IP && port == MY_PORT && len >= 8 && int'(len) <= MAXP + 8 && er_at < 0;
    if (ok) for (int i = 0; i < int'(len) - 8; i++) exp_q.push_back('{0, fr[42 + i], i == 0, len - 16'd8, 1'b0});
    if (ok && !odd) exp_q.push_back('{1, 8'h00, 1'b0, len - 16'd8,
                                      fcs_of(n - 4) == {fr[n - 1], fr[n - 2], fr[n - 3], fr[n - 4]}});
    else exp_q.push_back('{2, 8'h00, 1'b0, 16'd0, 1'b0});
  endtask
  task automatic nib(input logic [3:0] d, input logic e);
    eth_rx_data = d;
    eth_rx_er = e;
    eth_rx_dv = 1'b1;
    @(posedge eth_rx_clk);
    #1;
  endtask
  task automatic send(input int er_at, input bit odd, input int rst_at);
    repeat (15) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    foreach (fr[i]) begin
      nib(fr[i][3:0], i == er_at);
      if (i == rst_at) begin
        reset_i = 1'b1;
        #1;
        chk_zero("mid-frame reset");
      end
      nib(fr[i][7:4], 1'b0);
      reset_i = 1'b0;
    end
    if (odd) nib(4'($urandom), 1'b0);
    eth_rx_dv = 1'b0;
    eth_rx_er = 1'b0;
    eth_rx_data = '0;
    repeat (12) @(posedge eth_rx_clk);
    #1;
  endtask
  task automatic normal(input logic [47:0] dst, input logic [15:0] port);
    build(dst, port);
    add_fcs();
    model(-1, 1'b0);
    send(-1, 1'b0, -1);
  endtask
  initial begin
    int mut, er_at, k;
    bit odd;
    logic [15:0] bl;
    repeat (3) @(posedge eth_rx_clk);
    #1;
    chk_zero("reset");
    reset_i = 1'b0;
    repeat (3) @(posedge eth_rx_clk);
    #1;
    pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    normal(MY_MAC, MY_PORT);
    normal(MY_MAC, 16'h1F91);
    build(MY_MAC, MY_PORT);
    add_fcs();
    fr[fr.size() - 2] ^= 8'h10;
    model(-1, 1'b0);
    send(-1, 1'b0, -1);
    build(MY_MAC, MY_PORT);
    add_fcs();
    model(20, 1'b0);
    send(20, 1'b0, -1);
    normal(MY_MAC, MY_PORT);
    build(MY_MAC, MY_PORT);
    add_fcs();
    exp_q.push_back('{0, 8'hDE, 1'b1, 16'd4, 1'b0});
    send(-1, 1'b0, 43);
    normal(MY_MAC, MY_PORT);
    pay = {};
    normal(48'hFFFF_FFFF_FFFF, MY_PORT);
    pay = {};
    for (int i = 0; i < MAXP; i++) pay.push_back(8'($urandom));
    normal(MY_MAC, MY_PORT);
    for (int t = 0; t < 40; t++) begin
      pay = {};
      k = $urandom_range(0, MAXP);
      for (int i = 0; i < k; i++) pay.push_back(8'($urandom));
      build(MY_MAC, MY_PORT);
      mut = $urandom_range(0, 11);
      er_at = -1;
      odd = 1'b0;
      case (mut)
        1: fr[$urandom_range(0, 5)] ^= 8'($urandom_range(1, 255));
        2: for (int i = 0; i < 6; i++) fr[i] = 8'hFF;
        3: fr[12 + $urandom_range(0, 1)] ^= 8'($urandom_range(1, 255));
        4: fr[14] ^= 8'($urandom_range(1, 255));
        5: fr[23] ^= 8'($urandom_range(1, 255));
        6: fr[30 + $urandom_range(0, 3)] ^= 8'($urandom_range(1, 255));
        7: fr[36 + $urandom_range(0, 1)] ^= 8'($urandom_range(1, 255));
        8: begin
          bl = $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : 16'(MAXP + 9 + $urandom_range(0, 100));
          fr[38] = bl[15:8];
          fr[39] = bl[7:0];
        end
        10: er_at = $urandom_range(0, 41);
        11: odd = 1'b1;
        default: ;
      endcase
      add_fcs();
      if (mut == 9) fr[fr.size() - 1 - $urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
      model(er_at, odd);
      send(er_at, odd, -1);
    end
    repeat (20) @(posedge eth_rx_clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending events: got %0d outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
